// File: rtl/core_cmd_sequencer.sv
// Core command sequencer: FIFO-buffered command decode and single-strobe issue to the core.
// Optional error counter output err_cnt_o is enabled by defining CORE_SEQ_ERR_CNT_EN.
module core_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [8:0]  DONE_PIC_ADDR = 9'h1C0,
  parameter logic [8:0]  WSEL_BASE     = 9'h1D0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pkt_valid_i,
  input  logic [1:0] pkt_op_i,
  input  logic [8:0] pkt_addr_i,
  output logic       pkt_ready_o,
  output logic [8:0] addr_o,
  output logic       we_o,
  output logic       en_o,
  input  logic       pic_ack_i,
  output logic       busy_o,
  output logic       err_o
`ifdef CORE_SEQ_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt_o
`endif
);

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned ENT_W  = OP_W + ADDR_W;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [OP_W-1:0] OP_SLICE_WR = 2'b00;
  localparam logic [OP_W-1:0] OP_SPIKE_RD = 2'b01;
  localparam logic [OP_W-1:0] OP_WSEL     = 2'b10;
  localparam logic [OP_W-1:0] OP_DONE_PIC = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t state;

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              push_c;
  logic              pop_c;
  logic [OP_W-1:0]   head_op_c;
  logic [ADDR_W-1:0] head_addr_c;
  logic              illegal_c;
  logic [ADDR_W-1:0] issue_addr_c;
  logic              issue_we_c;
  logic              issue_c;
  logic [CNT_W-1:0]  count_nxt_c;
  state_t            state_nxt_c;

  // Handshake, head-of-queue decode and next-state computation
  always_comb begin
    push_c       = pkt_valid_i && pkt_ready_o;
    pop_c        = (state != WAIT_ACK) && (count != '0);
    head_op_c    = mem[rd_ptr][ENT_W-1:ADDR_W];
    head_addr_c  = mem[rd_ptr][ADDR_W-1:0];
    illegal_c    = 1'b0;
    issue_addr_c = head_addr_c;
    issue_we_c   = 1'b1;

    case (head_op_c)
      OP_SLICE_WR: illegal_c = (head_addr_c[8:6] == 3'b111);
      OP_SPIKE_RD: begin
        illegal_c  = head_addr_c[8];
        issue_we_c = 1'b0;
      end
      OP_WSEL:     issue_addr_c = WSEL_BASE | {5'b0_0000, head_addr_c[3:0]};
      default:     issue_addr_c = DONE_PIC_ADDR;
    endcase

    issue_c     = pop_c && !illegal_c;
    count_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);

    state_nxt_c = state;
    case (state)
      IDLE, ISSUE: begin
        if (!pop_c) begin
          state_nxt_c = IDLE;
        end else if (issue_c && (head_op_c == OP_DONE_PIC)) begin
          state_nxt_c = WAIT_ACK;
        end else begin
          state_nxt_c = ISSUE;
        end
      end
      WAIT_ACK: begin
        if (pic_ack_i) begin
          state_nxt_c = IDLE;
        end
      end
      default: state_nxt_c = IDLE;
    endcase
  end

  // Command storage; stale contents are harmless because count gates every read
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      mem[wr_ptr] <= {pkt_op_i, pkt_addr_i};
    end
  end

  // FSM, FIFO pointers and registered core-side outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      addr_o      <= '0;
      we_o        <= 1'b0;
      en_o        <= 1'b0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
      pkt_ready_o <= 1'b1;
    end else begin
      state <= state_nxt_c;
      count <= count_nxt_c;
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      en_o        <= issue_c;
      err_o       <= pop_c && illegal_c;
      addr_o      <= issue_c ? issue_addr_c : '0;
      we_o        <= issue_c && issue_we_c;
      // Registered from next-state values so they track the live count/state
      busy_o      <= (count_nxt_c != '0) || (state_nxt_c != IDLE);
      pkt_ready_o <= (count_nxt_c != FULL_CNT);
    end
  end

`ifdef CORE_SEQ_ERR_CNT_EN
  // Saturating count of dropped illegal commands
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_o <= '0;
    end else if (err_o && (err_cnt_o != 8'hFF)) begin
      err_cnt_o <= err_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_cmd_sequencer.sv
// Scoreboard bench for core_cmd_sequencer: directed latency/flow scenarios plus random traffic.
module tb_core_cmd_sequencer;

  logic       clk;
  logic       rst_i;
  logic       pkt_valid_i;
  logic [1:0] pkt_op_i;
  logic [8:0] pkt_addr_i;
  logic       pkt_ready_o;
  logic [8:0] addr_o;
  logic       we_o;
  logic       en_o;
  logic       pic_ack_i;
  logic       busy_o;
  logic       err_o;
`ifdef CORE_SEQ_ERR_CNT_EN
  logic [7:0] err_cnt_o;
`endif

  core_cmd_sequencer dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .pkt_valid_i (pkt_valid_i),
    .pkt_op_i    (pkt_op_i),
    .pkt_addr_i  (pkt_addr_i),
    .pkt_ready_o (pkt_ready_o),
    .addr_o      (addr_o),
    .we_o        (we_o),
    .en_o        (en_o),
    .pic_ack_i   (pic_ack_i),
    .busy_o      (busy_o),
    .err_o       (err_o)
`ifdef CORE_SEQ_ERR_CNT_EN
    ,
    .err_cnt_o   (err_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       err;
    logic [8:0] addr;
    logic       we;
  } exp_t;

  typedef struct {
    int         cyc;
    logic       en;
    logic       err;
    logic [8:0] addr;
    logic       we;
  } ev_t;

  exp_t sb[$];
  ev_t  log_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   err_exp = 0;
  logic wait_ack_m = 1'b0;
  logic stim_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected response of one command, straight from the opcode rules
  function automatic exp_t model(input logic [1:0] op, input logic [8:0] a);
    exp_t e;
    e.err = 1'b0;
    e.addr = a;
    e.we = 1'b1;
    case (op)
      2'd0: e.err = (a >= 9'd448);
      2'd1: begin e.err = (a >= 9'd256); e.we = 1'b0; end
      2'd2: e.addr = 9'(464 + (a % 16));
      default: e.addr = 9'd448;
    endcase
    if (e.err) begin
      e.addr = 9'd0;
      e.we = 1'b0;
    end
    return e;
  endfunction

  task automatic push_cmd(input logic [1:0] op, input logic [8:0] a, output int acc);
    int guard;
    exp_t e;
    guard = 0;
    pkt_valid_i = 1'b1;
    pkt_op_i = op;
    pkt_addr_i = a;
    while (!pkt_ready_o && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    acc = cyc;
    if (guard >= 300) begin
      check("push_timeout", 32'(pkt_ready_o), 32'd1);
    end else begin
      e = model(op, a);
      sb.push_back(e);
      if (e.err) err_exp++;
      @(negedge clk);
    end
    pkt_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_i = 1'b1;
    pkt_valid_i = 1'b0;
    pic_ack_i = 1'b0;
    sb.delete();
    log_q.delete();
    err_exp = 0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_ack(output int ack_cyc);
    @(posedge clk);
    #1 pic_ack_i = 1'b1;
    ack_cyc = cyc;
    @(posedge clk);
    #1 pic_ack_i = 1'b0;
    @(negedge clk);
  endtask

  // Output monitor: pops the scoreboard on every strobe or error pulse
  task automatic monitor();
    exp_t e;
    ev_t ev;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        wait_ack_m = 1'b0;
      end else begin
        if (en_o || err_o) begin
          ev.cyc = cyc; ev.en = en_o; ev.err = err_o; ev.addr = addr_o; ev.we = we_o;
          log_q.push_back(ev);
          if (wait_ack_m) check("issue_in_wait_ack", 32'(en_o | err_o), 32'd0);
          if (sb.size() == 0) begin
            check("unexpected_output", 32'(en_o | err_o), 32'd0);
          end else begin
            e = sb.pop_front();
            check("out_err", 32'(err_o), 32'(e.err));
            check("out_en", 32'(en_o), 32'(!e.err));
            check("out_addr", 32'(addr_o), 32'(e.addr));
            check("out_we", 32'(we_o), 32'(e.we));
          end
          if (en_o && addr_o == 9'd448) wait_ack_m = 1'b1;
        end else begin
          check("idle_bus_zero", {22'd0, addr_o, we_o}, 32'd0);
        end
        if (pic_ack_i) wait_ack_m = 1'b0;
      end
    end
  endtask

  initial begin
    int n, t, a;
    rst_i = 1'b1;
    pkt_valid_i = 1'b0;
    pkt_op_i = 2'd0;
    pkt_addr_i = 9'd0;
    pic_ack_i = 1'b0;
    stim_done = 1'b0;
    fork
      monitor();
      begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    do_reset();
    check("rst_addr", 32'(addr_o), 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_en", 32'(en_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(pkt_ready_o), 32'd1);

    // Scenario 1: single slice write, N+2 latency
    push_cmd(2'd0, 9'd5, n);
    repeat (6) @(negedge clk);
    check("s1_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) check("s1_latency", 32'(log_q[0].cyc), 32'(n + 2));

    // Scenario 2: back-to-back spike reads
    do_reset();
    push_cmd(2'd1, 9'd10, n);
    push_cmd(2'd1, 9'd11, t);
    push_cmd(2'd1, 9'd12, t);
    repeat (6) @(negedge clk);
    check("s2_count", 32'(log_q.size()), 32'd3);
    for (int i = 0; i < log_q.size() && i < 3; i++)
      check("s2_cycle", 32'(log_q[i].cyc), 32'(n + 2 + i));

    // Scenario 3: done picture then weight select, gated by ack
    do_reset();
    push_cmd(2'd3, 9'd0, n);
    push_cmd(2'd2, 9'h1F3, t);
    repeat (2) @(negedge clk);
    check("s3_busy_wait", 32'(busy_o), 32'd1);
    pulse_ack(a);
    repeat (5) @(negedge clk);
    check("s3_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("s3_pic_cycle", 32'(log_q[0].cyc), 32'(n + 2));
      check("s3_wsel_addr", 32'(log_q[1].addr), 32'd467);
      check("s3_wsel_cycle", 32'(log_q[1].cyc), 32'(a + 2));
    end

    // Scenario 4: FIFO fills while waiting for ack
    do_reset();
    push_cmd(2'd3, 9'd0, n);
    for (int i = 0; i < 4; i++) push_cmd(2'd0, 9'(20 + i), t);
    check("s4_full_ready", 32'(pkt_ready_o), 32'd0);
    pkt_valid_i = 1'b1;
    pkt_op_i = 2'd0;
    pkt_addr_i = 9'd24;
    repeat (4) @(negedge clk);
    check("s4_held_ready", 32'(pkt_ready_o), 32'd0);
    check("s4_only_pic", 32'(log_q.size()), 32'd1);
    check("s4_sb_pending", 32'(sb.size()), 32'd4);
    pulse_ack(a);
    push_cmd(2'd0, 9'd24, t);
    repeat (12) @(negedge clk);
    check("s4_total", 32'(log_q.size()), 32'd6);
    check("s4_drained", 32'(sb.size()), 32'd0);

    // Scenario 5: two illegal commands
    do_reset();
    push_cmd(2'd0, 9'd450, n);
    push_cmd(2'd1, 9'd300, t);
    repeat (5) @(negedge clk);
    check("s5_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("s5_err0", 32'(log_q[0].err), 32'd1);
      check("s5_err1", 32'(log_q[1].err), 32'd1);
      check("s5_err0_cycle", 32'(log_q[0].cyc), 32'(n + 2));
    end
`ifdef CORE_SEQ_ERR_CNT_EN
    check("s5_err_cnt", 32'(err_cnt_o), 32'd2);
`endif

    // Scenario 6: reset while waiting with commands queued
    do_reset();
    push_cmd(2'd3, 9'd0, n);
    for (int i = 1; i <= 3; i++) push_cmd(2'd1, 9'(i), t);
    repeat (3) @(negedge clk);
    check("s6_busy_before", 32'(busy_o), 32'd1);
    do_reset();
    check("s6_busy_after", 32'(busy_o), 32'd0);
    check("s6_ready_after", 32'(pkt_ready_o), 32'd1);
    pulse_ack(a);
    repeat (4) @(negedge clk);
    check("s6_no_issue", 32'(log_q.size()), 32'd0);
    check("s6_idle_busy", 32'(busy_o), 32'd0);
    push_cmd(2'd0, 9'd5, n);
    repeat (5) @(negedge clk);
    check("s6_fresh_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) check("s6_fresh_latency", 32'(log_q[0].cyc), 32'(n + 2));

    // Random traffic with a randomly delayed ack responder
    do_reset();
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          push_cmd(2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)), t);
        end
        stim_done = 1'b1;
      end
      begin
        int cd;
        int guard;
        cd = 0;
        guard = 0;
        while (!(stim_done && sb.size() == 0 && !busy_o) && guard < 20000) begin
          @(posedge clk);
          #1;
          guard++;
          pic_ack_i = 1'b0;
          if (cd > 0) begin
            cd--;
            if (cd == 0) pic_ack_i = 1'b1;
          end else if (en_o && addr_o == 9'd448) begin
            cd = $urandom_range(1, 6);
          end
        end
        pic_ack_i = 1'b0;
        if (guard >= 20000) check("rand_drain_timeout", 32'(busy_o), 32'd0);
      end
    join
    repeat (3) @(negedge clk);
    check("rand_sb_empty", 32'(sb.size()), 32'd0);
    check("rand_busy_end", 32'(busy_o), 32'd0);
    check("rand_ready_end", 32'(pkt_ready_o), 32'd1);
`ifdef CORE_SEQ_ERR_CNT_EN
    check("rand_err_cnt", 32'(err_cnt_o), 32'((err_exp > 255) ? 255 : err_exp));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
